// File: rtl/bubble_seq_sorter.sv
// Block sorter: loads DIM words, sorts with DIM odd-even transposition passes, streams out ascending.
// Latency: first output DIM cycles after the last input handshake; DIM outputs then follow, one per ready cycle.
// Backpressure: in_ready is low in SORT/DRAIN; out_data/out_valid/out_last hold while out_ready is low.
//
// Ports: clk/rst (async active-high); in_valid/in_ready/in_data load stream;
//        out_valid/out_ready/out_data/out_last sorted stream; busy = SORT or DRAIN.

// Min/max compare-exchange element: lo gets the smaller value, hi the larger.
// Equal inputs pass through unchanged.
module pair_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic swap;
  assign swap = (b < a);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

module bubble_seq_sorter #(
  parameter int DIM   = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = $clog2(DIM);
  localparam int PW = CW + 1;
  localparam logic [CW-1:0] LAST_IDX   = CW'(DIM - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(DIM - 1);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx;
  logic [PW-1:0]    phase;
  logic [WIDTH-1:0] mem      [DIM];
  logic [WIDTH-1:0] mem_nxt  [DIM];
  logic [WIDTH-1:0] lo       [DIM-1];
  logic [WIDTH-1:0] hi       [DIM-1];

  // One compare-exchange element per adjacent pair; the phase parity picks
  // which pairs actually write back.
  for (genvar k = 0; k < DIM - 1; k++) begin : g_pair
    pair_swap #(.WIDTH(WIDTH)) u_swap (
      .a  (mem[k]),
      .b  (mem[k+1]),
      .lo (lo[k]),
      .hi (hi[k])
    );
  end

  // Pair (k,k+1) is active when k has the same parity as the phase. Interior
  // elements always belong to exactly one active pair (left or right), while
  // the end elements may sit out a phase.
  for (genvar g = 0; g < DIM; g++) begin : g_elem
    if (g == 0) begin : g_first
      assign mem_nxt[g] = phase[0] ? mem[g] : lo[g];
    end else if (g == DIM - 1) begin : g_last
      assign mem_nxt[g] = (phase[0] == 1'((g - 1) % 2)) ? hi[g-1] : mem[g];
    end else begin : g_mid
      assign mem_nxt[g] = (phase[0] == 1'((g - 1) % 2)) ? hi[g-1] : lo[g];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
      idx   <= '0;
      phase <= '0;
      for (int i = 0; i < DIM; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          if (in_valid) begin
            mem[cnt] <= in_data;
            cnt      <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
          end
        end
        SORT: begin
          for (int i = 0; i < DIM; i++) mem[i] <= mem_nxt[i];
          phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
        end
        DRAIN: begin
          if (out_ready) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST_IDX) state_nxt = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (phase == LAST_PHASE) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && idx == LAST_IDX) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Storage is cleared on reset, so out_data reads as zero there without gating.
  assign out_data = mem[idx];
  assign out_last = out_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_bubble_seq_sorter.sv
module tb_bubble_seq_sorter;
  localparam int DIM = 8;
  localparam int W   = 8;
  localparam int D5  = 5;
  localparam int W5  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [W-1:0] in_data, out_data;

  logic          in_valid5, in_ready5, out_valid5, out_ready5, out_last5, busy5;
  logic [W5-1:0] in_data5, out_data5;

  bubble_seq_sorter #(.DIM(DIM), .WIDTH(W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  bubble_seq_sorter #(.DIM(D5), .WIDTH(W5)) u_dut5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .out_last(out_last5), .busy(busy5)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs: {last, data}
  logic [W:0]  exp_q  [$];
  logic [W5:0] exp5_q [$];

  // Reference: each element's output position is its rank (stable for ties).
  task automatic push_block(input logic [W-1:0] v [DIM]);
    logic [W-1:0] s [DIM];
    for (int i = 0; i < DIM; i++) begin
      int pos = 0;
      for (int j = 0; j < DIM; j++)
        if (v[j] < v[i] || (v[j] == v[i] && j < i)) pos++;
      s[pos] = v[i];
    end
    for (int i = 0; i < DIM; i++) exp_q.push_back({(i == DIM - 1), s[i]});
  endtask

  task automatic push_block5(input logic [W5-1:0] v [D5]);
    logic [W5-1:0] s [D5];
    for (int i = 0; i < D5; i++) begin
      int pos = 0;
      for (int j = 0; j < D5; j++)
        if (v[j] < v[i] || (v[j] == v[i] && j < i)) pos++;
      s[pos] = v[i];
    end
    for (int i = 0; i < D5; i++) exp5_q.push_back({(i == D5 - 1), s[i]});
  endtask

  task automatic send_block(input logic [W-1:0] v [DIM], input bit expect_it);
    if (expect_it) push_block(v);
    for (int i = 0; i < DIM; i++) begin
      int n = 0;
      in_valid = 1'b1;
      in_data  = v[i];
      @(negedge clk);
      while (!in_ready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block5(input logic [W5-1:0] v [D5]);
    push_block5(v);
    for (int i = 0; i < D5; i++) begin
      int n = 0;
      in_valid5 = 1'b1;
      in_data5  = v[i];
      @(negedge clk);
      while (!in_ready5 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready5) check("in_ready5_timeout", in_ready5, 1);
      @(posedge clk);
      #1;
    end
    in_valid5 = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp5_q.size() != 0) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size() + exp5_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // out_ready driver: 0 = always ready, 1 = pattern 1,0,0, 2 = random (~75% ready)
  int rdy_mode = 0;
  initial begin
    int pat = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          out_ready = (pat == 0);
          pat = (pat + 1) % 3;
        end
        2: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor for the DIM=8 instance
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic         prev_last_hs = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, prev_data);
      end
      if (prev_last_hs) begin
        check("in_ready_after_last", in_ready, 1);
        check("out_valid_after_last", out_valid, 0);
      end
      if (out_valid) begin
        check("in_ready_low_in_drain", in_ready, 0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            check("out_data", out_data, e[W-1:0]);
            check("out_last", out_last, e[W]);
          end
        end
      end
      prev_stall   = out_valid && !out_ready;
      prev_data    = out_data;
      prev_last_hs = out_valid && out_ready && out_last;
    end
  end

  // Monitor for the odd DIM=5 instance (always ready)
  always @(negedge clk) begin
    if (!rst && out_valid5 && out_ready5) begin
      if (exp5_q.size() == 0) begin
        check("unexpected_output5", 1, 0);
      end else begin
        logic [W5:0] e;
        e = exp5_q.pop_front();
        check("out_data5", out_data5, e[W5-1:0]);
        check("out_last5", out_last5, e[W5]);
      end
    end
  end

  initial begin
    logic [W-1:0]  v  [DIM];
    logic [W5-1:0] v5 [D5];

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid5 = 1'b0;
    in_data5  = '0;
    out_ready5 = 1'b1;

    // Asynchronous reset before any clock edge
    #3 rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;

    // Reverse order with latency check
    rdy_mode = 0;
    v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send_block(v, 1'b1);
    check("sort_busy", busy, 1);
    repeat (DIM - 1) @(posedge clk);
    #1;
    check("latency_not_yet_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("latency_valid", out_valid, 1);
    wait_drain();

    // Duplicates and extremes
    v = '{8'd255, 8'd0, 8'd7, 8'd7, 8'd255, 8'd0, 8'd128, 8'd7};
    send_block(v, 1'b1);
    wait_drain();

    // Backpressure pattern 1,0,0
    rdy_mode = 1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < DIM; i++) v[i] = W'($urandom_range(0, 255));
      send_block(v, 1'b1);
    end
    wait_drain();

    // Reset during SORT phase 3, then a clean block
    rdy_mode = 0;
    v = '{8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1};
    send_block(v, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("mid_sort_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    v = '{8'd5, 8'd1, 8'd4, 8'd2, 8'd3, 8'd9, 8'd8, 8'd6};
    send_block(v, 1'b1);
    wait_drain();

    // Random regression with random backpressure
    rdy_mode = 2;
    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < DIM; i++) v[i] = W'($urandom_range(0, 255));
      send_block(v, 1'b1);
    end
    wait_drain();

    // Odd DIM instance
    for (int b = 0; b < 200; b++) begin
      for (int i = 0; i < D5; i++) v5[i] = W5'($urandom_range(0, 15));
      send_block5(v5);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
